// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner ids, transaction record.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Transaction fields are sized for the widest supported data width; the arbiter
    // resizes to its own BIT_COUNT at the boundary.
    localparam int TXN_DATA_W = 64;
    localparam int TXN_ADDR_W = 32;
    localparam int TXN_MASK_W = TXN_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_I = 2'd1,
        ISSUE_D = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic                  we;
        logic [TXN_ADDR_W-1:0] addr;
        logic [TXN_DATA_W-1:0] wdata;
        logic [TXN_MASK_W-1:0] wmask;
    } mem_txn_t;

    // The counter only has to hold 0 .. cycles-1 before it expires.
    function automatic int timeout_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mem_arb_timeout_counter.sv
// Counts consecutive stalled issue cycles and flags expiry on the last allowed one.
// Latency: expire is combinational from the count and enable (same-cycle).
// Backpressure: none; clear wins over enable, count freezes once expired.
module mem_arb_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Expire fires during the TIMEOUT_CYCLES-th stalled cycle so the FSM leaves on that edge.
    assign expire = enable && (cnt == LAST_CNT);

    // Count stalled cycles; restart whenever the arbiter is not issuing.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports, one transaction at a time.
// Latency: req in IDLE -> mem_req next cycle; mem_ready at k -> x_done at k+1 -> next grant at k+2.
// Backpressure: requesters hold req until done; mem_req holds until mem_ready or timeout.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate the tie-break between ports instead of data-first.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BIT_COUNT      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic                   i_done,
    output logic [BIT_COUNT-1:0]   i_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [ADDR_WIDTH-1:0]  d_addr,
    input  logic [BIT_COUNT-1:0]   d_wdata,
    input  logic [BIT_COUNT/8-1:0] d_wmask,
    output logic                   d_done,
    output logic [BIT_COUNT-1:0]   d_rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [BIT_COUNT-1:0]   mem_wdata,
    output logic [BIT_COUNT/8-1:0] mem_wmask,
    input  logic                   mem_ready,
    input  logic [BIT_COUNT-1:0]   mem_rdata,
    output logic                   timeout_err
);

    arb_state_t           state;
    mem_txn_t             txn;
    logic                 issuing;
    logic                 tmo_expire;
    logic                 pick_d;
    logic                 grant_d;
    logic [BIT_COUNT-1:0] resp_data;

    assign issuing = (state == ISSUE_I) || (state == ISSUE_D);

    // Stores and timeouts return zero; loads and fetches return the memory word.
    assign resp_data = (mem_ready && !txn.we) ? mem_rdata : '0;

    assign mem_we    = txn.we;
    assign mem_addr  = ADDR_WIDTH'(txn.addr);
    assign mem_wdata = BIT_COUNT'(txn.wdata);
    assign mem_wmask = (BIT_COUNT/8)'(txn.wmask);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    // On a tie the port that did not own the memory last time goes first.
    assign pick_d = (last_owner == OWNER_I);

    // Remember who was granted most recently; fetch counts as last owner out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWNER_I;
        end else if (state == IDLE) begin
            if (grant_d) begin
                last_owner <= OWNER_D;
            end else if (i_req) begin
                last_owner <= OWNER_I;
            end
        end
    end
`else
    assign pick_d = 1'b1;
`endif

    // A lone requester always wins; pick_d only settles a tie.
    assign grant_d = d_req && (!i_req || pick_d);

    mem_arb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!issuing),
        .enable (issuing && !mem_ready),
        .expire (tmo_expire)
    );

    // Arbitration FSM: grant only from IDLE, hold the request through ISSUE, pulse done in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            txn         <= '0;
            mem_req     <= 1'b0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        txn <= '{we:    d_we,
                                 addr:  TXN_ADDR_W'(d_addr),
                                 wdata: TXN_DATA_W'(d_wdata),
                                 wmask: TXN_MASK_W'(d_wmask)};
                        mem_req <= 1'b1;
                        state   <= ISSUE_D;
                    end else if (i_req) begin
                        txn <= '{we:    1'b0,
                                 addr:  TXN_ADDR_W'(i_addr),
                                 wdata: '0,
                                 wmask: '0};
                        mem_req <= 1'b1;
                        state   <= ISSUE_I;
                    end
                end
                ISSUE_I, ISSUE_D: begin
                    // A ready arriving on the expiry cycle still completes normally.
                    if (mem_ready || tmo_expire) begin
                        if (!mem_ready) begin
                            timeout_err <= 1'b1;
                        end
                        if (state == ISSUE_I) begin
                            i_rdata <= resp_data;
                            i_done  <= 1'b1;
                        end else begin
                            d_rdata <= resp_data;
                            d_done  <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand-written corner sequences.
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: memory latency is set per vector; every wait is bounded.
module tb_mem_port_arbiter;

    localparam int BW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [BW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [BW-1:0] d_wdata;
    logic [3:0]    d_wmask;
    logic          d_done;
    logic [BW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_ready;
    logic [BW-1:0] mem_rdata;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .BIT_COUNT      (BW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_done      (i_done),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wmask     (d_wmask),
        .d_done      (d_done),
        .d_rdata     (d_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [3:0]    wmask;
        logic [BW-1:0] rdata;
        int            lat;
        logic [BW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.wmask;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        tick();
        for (int c = 1; c <= v.lat; c++) begin
            check($sformatf("v%0d c%0d mem_req", n, c), 64'(mem_req), 64'd1);
            check($sformatf("v%0d c%0d mem_addr", n, c), 64'(mem_addr), 64'(v.addr));
            check($sformatf("v%0d c%0d mem_we", n, c), 64'(mem_we), 64'(v.is_d & v.we));
            check($sformatf("v%0d c%0d mem_wmask", n, c), 64'(mem_wmask), v.is_d ? 64'(v.wmask) : 64'd0);
            if (v.is_d)
                check($sformatf("v%0d c%0d mem_wdata", n, c), 64'(mem_wdata), 64'(v.wdata));
            check($sformatf("v%0d c%0d done", n, c), 64'({i_done, d_done}), 64'd0);
            // Scribble on the requester inputs; the issued transaction must not follow them.
            if (v.is_d) begin
                d_addr = v.addr ^ 32'h40; d_wdata = ~v.wdata;
            end else begin
                i_addr = v.addr ^ 32'h40;
            end
            if (c == v.lat) begin
                mem_ready = 1'b1; mem_rdata = v.rdata;
            end else begin
                mem_ready = 1'b0; mem_rdata = 32'hBAD0BAD0;
            end
            tick();
        end
        mem_ready = 1'b0;
        check($sformatf("v%0d resp mem_req", n), 64'(mem_req), 64'd0);
        check($sformatf("v%0d resp i_done", n), 64'(i_done), 64'(!v.is_d));
        check($sformatf("v%0d resp d_done", n), 64'(d_done), 64'(v.is_d));
        check($sformatf("v%0d resp rdata", n), v.is_d ? 64'(d_rdata) : 64'(i_rdata), 64'(v.exp_rdata));
        i_req = 1'b0; d_req = 1'b0;
        tick();
        check($sformatf("v%0d idle done", n), 64'({i_done, d_done}), 64'd0);
        check($sformatf("v%0d idle mem_req", n), 64'(mem_req), 64'd0);
        tick();
        check($sformatf("v%0d no reissue", n), 64'(mem_req), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0050_0093, 1, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 3, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0104, 32'h0000_A5A5, 4'h3, 32'hFFFF_FFFF, 1, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF};

        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; d_wmask = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        check("reset mem_req", 64'(mem_req), 64'd0);
        check("reset dones", 64'({i_done, d_done}), 64'd0);
        check("reset mem_fields", 64'({mem_we, mem_wmask}) | 64'(mem_addr) | 64'(mem_wdata), 64'd0);
        check("reset rdata", 64'(i_rdata) | 64'(d_rdata), 64'd0);
        check("reset timeout_err", 64'(timeout_err), 64'd0);
        reset = 1'b0;
        tick();

        for (int n = 0; n < 5; n++) run_vec(n, vecs[n]);

        // Simultaneous requests: the store goes first, fetch is granted two cycles after d_done.
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF;
        tick();
        check("sim c1 mem_we", 64'(mem_we), 64'd1);
        check("sim c1 mem_addr", 64'(mem_addr), 64'h100);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ready = 1'b0;
        check("sim d_done", 64'(d_done), 64'd1);
        check("sim d_rdata", 64'(d_rdata), 64'd0);
        check("sim i_done early", 64'(i_done), 64'd0);
        d_req = 1'b0;
        tick();
        check("sim gap mem_req", 64'(mem_req), 64'd0);
        tick();
        check("sim fetch mem_req", 64'(mem_req), 64'd1);
        check("sim fetch mem_addr", 64'(mem_addr), 64'h20);
        check("sim fetch mem_we", 64'(mem_we), 64'd0);
        mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        tick();
        mem_ready = 1'b0;
        check("sim i_done", 64'({i_done, d_done}), 64'b10);
        check("sim i_rdata", 64'(i_rdata), 64'h13);
        i_req = 1'b0;
        tick(); tick();

        // Timeout: no mem_ready for TMO issue cycles.
        i_req = 1'b1; i_addr = 32'h30;
        tick();
        for (int c = 1; c <= TMO; c++) begin
            check($sformatf("tmo c%0d mem_req", c), 64'(mem_req), 64'd1);
            check($sformatf("tmo c%0d err", c), 64'(timeout_err), 64'd0);
            check($sformatf("tmo c%0d i_done", c), 64'(i_done), 64'd0);
            tick();
        end
        check("tmo i_done", 64'(i_done), 64'd1);
        check("tmo i_rdata", 64'(i_rdata), 64'd0);
        check("tmo err set", 64'(timeout_err), 64'd1);
        check("tmo mem_req", 64'(mem_req), 64'd0);
        i_req = 1'b0;
        tick(); tick(); tick();
        check("tmo err sticky idle", 64'(timeout_err), 64'd1);
        i_req = 1'b1; i_addr = 32'h34;
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ready = 1'b0;
        check("tmo post i_done", 64'(i_done), 64'd1);
        check("tmo post i_rdata", 64'(i_rdata), 64'h77);
        check("tmo err sticky txn", 64'(timeout_err), 64'd1);
        i_req = 1'b0;
        tick(); tick();

        // Reset in the second ISSUE_D cycle abandons the load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        check("rst c1 mem_req", 64'(mem_req), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check("rst mem_req", 64'(mem_req), 64'd0);
        check("rst dones", 64'({i_done, d_done}), 64'd0);
        check("rst err cleared", 64'(timeout_err), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0; d_req = 1'b0;
        tick();
        check("rst after dones", 64'({i_done, d_done}), 64'd0);
        check("rst after mem_req", 64'(mem_req), 64'd0);
        i_req = 1'b1; i_addr = 32'h44;
        tick();
        check("rst idle grant", 64'(mem_req), 64'd1);
        check("rst idle addr", 64'(mem_addr), 64'h44);
        mem_ready = 1'b1; mem_rdata = 32'h99;
        tick();
        mem_ready = 1'b0;
        check("rst idle i_done", 64'(i_done), 64'd1);
        i_req = 1'b0;
        tick(); tick();

        // Both ports requesting continuously: grant order depends on the tie-break.
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        for (int g = 0; g < 4; g++) begin
            int  waited;
            logic exp_d;
            waited = 0;
            while (!mem_req && waited < 8) begin
                tick();
                waited++;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (g % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            check($sformatf("arb g%0d mem_req", g), 64'(mem_req), 64'd1);
            check($sformatf("arb g%0d addr", g), 64'(mem_addr), exp_d ? 64'h2000 : 64'h1000);
            mem_ready = 1'b1; mem_rdata = 32'(g + 1);
            tick();
            mem_ready = 1'b0;
            check($sformatf("arb g%0d done", g), 64'({i_done, d_done}), exp_d ? 64'b01 : 64'b10);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the core.
- Sits between the ComputeCore fetch/memory stages and the memory model; it replaces the dual instruction/data memory arrangement.
- Sequences one memory transaction at a time, returns read data and a completion pulse to the owning requester, and flags memory timeouts.

Parameters:
- BIT_COUNT, 32, data width (32 or 64; matches the `BIT_COUNT build setting).
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 64, maximum cycles in an issue state without mem_ready before the timeout fires; must be >= 1.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_done
- i_addr  in  ADDR_WIDTH  fetch address
- i_done  out  1  one-cycle completion pulse
- i_rdata  out  BIT_COUNT  fetch data; valid only when i_done=1
- d_req  in  1  data request; held with all d_* inputs until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  BIT_COUNT  store data
- d_wmask  in  BIT_COUNT/8  byte-lane write enables
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  BIT_COUNT  load data; valid when d_done=1; 0 for stores
- mem_req  out  1  transaction active; held until mem_ready
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_WIDTH/BIT_COUNT/BIT_COUNT/8  registered copy of the granted request
- mem_ready  in  1  memory completes the transaction this cycle
- mem_rdata  in  BIT_COUNT  read data, sampled when mem_ready=1
- timeout_err  out  1  sticky error flag

Behaviour:
- Reset: all outputs are 0, state=IDLE, timeout counter=0. Reset mid-transaction abandons it; no done pulse is issued.
- State machine: IDLE, ISSUE_I, ISSUE_D, RESP.
  - IDLE: if d_req, latch the d_* fields into the mem_* registers and go to ISSUE_D. Else if i_req, latch i_addr with we=0 and mask=0, and go to ISSUE_I. Else stay in IDLE.
  - Default priority: data over fetch when both are requesting.
  - ISSUE_x: mem_req=1. On mem_ready, capture mem_rdata into x_rdata (0 if it was a store), then go to RESP.
  - RESP: pulse the owner's x_done for exactly one cycle, mem_req=0, then go to IDLE.
- No arbitration happens in RESP. This guarantees a requester dropping req after done is never re-issued.
- Latency: req seen in IDLE at cycle 0 -> mem_req=1 at cycle 1 -> mem_ready at cycle k (k >= 1) -> x_done at k+1 -> next grant possible at k+2.
- mem_* fields stay constant for the whole ISSUE state. Requester inputs changing mid-transaction are ignored.
- Timeout:
  - The counter increments every ISSUE cycle without mem_ready and clears on leaving ISSUE.
  - When it reaches TIMEOUT_CYCLES, the arbiter sets timeout_err and goes to RESP with rdata=0; the requester still gets done.
  - timeout_err clears only on reset.
- mem_ready while in IDLE or RESP is ignored.
- i_done and d_done are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a last_owner flop (reset value fetch) sets the tie-break. When both requesters are pending in IDLE, the port that was not the last owner wins. A lone requester always wins.
- Undefined: fixed data-over-fetch priority. last_owner is not built.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the arb_state_t enum (IDLE, ISSUE_I, ISSUE_D, RESP)
  - the owner_t enum (OWNER_I, OWNER_D)
  - a mem_txn_t struct (we, addr, wdata, wmask)
  - the TIMEOUT counter width function
- One natural sub-module: mem_arb_timeout_counter (counter plus compare, with clear/enable inputs, outputs expire).

Test Plan:
- Fetch-only read: i_req with i_addr=0x10, memory returns 0x00500093 with mem_ready in cycle 1 -> mem_req high cycles 1–1; i_done=1 with i_rdata=0x00500093 at cycle 2; d_done never asserted.
- Simultaneous requests: i_req plus a d_req store (addr 0x100, wdata 0xDEADBEEF, mask 0xF) in the same cycle, memory latency 2 -> the store is issued first with d_rdata=0; the fetch is granted 2 cycles after d_done.
- Back-to-back stall: memory latency 3, d_req held -> mem_* stable for all 3 ISSUE cycles; exactly one d_done; the request is not re-issued after d_req drops.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held at 0 -> after 4 ISSUE cycles timeout_err=1 and i_done with i_rdata=0; timeout_err stays 1 until reset.
- Reset mid-transaction: reset asserted in ISSUE_D cycle 2 -> the next cycle has mem_req=0, no done pulse, state IDLE.
- With MEM_ARB_ROUND_ROBIN_EN: both ports continuously requesting -> grants alternate D, I, D, I.
